// File: rtl/mul8u_sweep_eval_pkg.sv
// Shared constants and types for the multiplier sweep evaluator.
//   WIDTH        : operand width of the multiplier under test
//   PAIR_COUNT   : number of operand pairs in one sweep (2^(2*WIDTH))
//   DRAIN_CYCLES : cycles after the last pair needed to empty S1..S3
//   state_t      : sweep sequencer states
//   err_stage_t  : contents of the S2 (error) pipeline register
package mul8u_eval_pkg;
   localparam int WIDTH        = 8;
   localparam int PAIR_COUNT   = 65536;
   localparam int DRAIN_CYCLES = 2;

   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

   typedef struct packed {
      logic [WIDTH-1:0]   a;
      logic [WIDTH-1:0]   b;
      logic [2*WIDTH-1:0] err;
      logic               valid;
   } err_stage_t;
endpackage

// File: rtl/mul8u_sweep_eval_if.sv
// Operand/product bus between the evaluator and the combinational multiplier
// under test.
//   op_a, op_b : operands driven by the evaluator (master)
//   prod_in    : product returned by the multiplier (slave), combinational
//                from op_a/op_b, sampled in the same cycle
interface mul8u_sweep_eval_if
   import mul8u_eval_pkg::*;
#(
   parameter int WIDTH = mul8u_eval_pkg::WIDTH
);
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic [2*WIDTH-1:0] prod_in;

   modport master (output op_a, output op_b, input prod_in);
   modport slave  (input op_a, input op_b, output prod_in);
endinterface

// File: rtl/mul8u_sweep_eval_err_stage.sv
// Combinational error calculation for one operand pair: exact unsigned
// product and absolute difference to the observed product.
//   a, b : operands
//   prod : product reported by the multiplier under test
//   err  : |prod - a*b|
module mul8u_err_stage
   import mul8u_eval_pkg::*;
#(
   parameter int WIDTH = mul8u_eval_pkg::WIDTH
) (
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [2*WIDTH-1:0] prod,
   output logic [2*WIDTH-1:0] err
);
   logic [2*WIDTH-1:0] exact;

   assign exact = (2*WIDTH)'(a) * (2*WIDTH)'(b);
   // Subtract the smaller from the larger so the result never wraps.
   assign err   = (prod >= exact) ? (prod - exact) : (exact - prod);
endmodule

// File: rtl/mul8u_sweep_eval.sv
// Exhaustive sweep evaluator for an unsigned WIDTHxWIDTH multiplier.
// Presents every operand pair once, compares each product with the exact
// one and accumulates error statistics.
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   start       : request a sweep; honoured only in IDLE
//   busy        : high from first SWEEP cycle through last DRAIN cycle
//   done        : one-cycle pulse when statistics are final
//   mul         : operand/product bus to the multiplier under test
//   sum_abs_err : saturating sum of absolute errors
//   err_count   : number of pairs with nonzero error
//   max_err     : largest absolute error, max_err_a/b its first operands
//   state_dbg   : current sequencer state
// Handshake: start is a level sampled on each rising edge; it is accepted
// only while idle (busy=0, done=0), and every accepted start produces exactly
// one done pulse unless rst intervenes.
module mul8u_sweep_eval
   import mul8u_eval_pkg::*;
#(
   parameter int WIDTH = mul8u_eval_pkg::WIDTH,
   parameter int ACC_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   mul8u_sweep_eval_if.master    mul,
   output logic [ACC_W-1:0]      sum_abs_err,
   output logic [2*WIDTH:0]      err_count,
   output logic [2*WIDTH-1:0]    max_err,
   output logic [WIDTH-1:0]      max_err_a,
   output logic [WIDTH-1:0]      max_err_b,
   output state_t                state_dbg
);
   state_t             state, state_next;
   logic [2*WIDTH-1:0] pair_k;
   logic [1:0]         drain_cnt;
   logic               load_start;
   logic               last_pair;
   logic               drain_last;

   assign last_pair  = (pair_k == (2*WIDTH)'(PAIR_COUNT - 1));
   assign drain_last = (drain_cnt == 2'(DRAIN_CYCLES - 1));
   assign state_dbg  = state;

   // ---------------- sequencer ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      load_start = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = SWEEP;
               load_start = 1'b1;
            end
         end
         SWEEP: begin
            busy = 1'b1;
            if (last_pair) state_next = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (drain_last) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Pair counter stops on the last pair, so the operands hold (max,max)
   // until the next sweep is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pair_k    <= '0;
         drain_cnt <= '0;
      end else begin
         if (load_start)                        pair_k <= '0;
         else if (state == SWEEP && !last_pair) pair_k <= pair_k + 1'b1;
         if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
         else                drain_cnt <= '0;
      end
   end

   assign mul.op_a = pair_k[2*WIDTH-1:WIDTH];
   assign mul.op_b = pair_k[WIDTH-1:0];

   // ---------------- S1: capture operands and product ----------------
   logic [WIDTH-1:0]   s1_a, s1_b;
   logic [2*WIDTH-1:0] s1_prod;
   logic               s1_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_a     <= '0;
         s1_b     <= '0;
         s1_prod  <= '0;
         s1_valid <= 1'b0;
      end else begin
         s1_a     <= mul.op_a;
         s1_b     <= mul.op_b;
         s1_prod  <= mul.prod_in;
         s1_valid <= (state == SWEEP);
      end
   end

   // ---------------- S2: absolute error ----------------
   logic [2*WIDTH-1:0] err_c;
   err_stage_t         s2;

   mul8u_err_stage #(.WIDTH(WIDTH)) u_err (
      .a    (s1_a),
      .b    (s1_b),
      .prod (s1_prod),
      .err  (err_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2 <= '0;
      end else begin
         s2.a     <= s1_a;
         s2.b     <= s1_b;
         s2.err   <= err_c;
         s2.valid <= s1_valid;
      end
   end

   // ---------------- S3: statistics ----------------
   // One extra bit catches the carry out; once saturated the sum stays at
   // all-ones because any further addition carries out again or adds zero.
   logic [ACC_W:0] sum_ext;
   assign sum_ext = {1'b0, sum_abs_err} + (ACC_W+1)'(s2.err);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_abs_err <= '0;
         err_count   <= '0;
         max_err     <= '0;
         max_err_a   <= '0;
         max_err_b   <= '0;
      end else if (load_start) begin
         sum_abs_err <= '0;
         err_count   <= '0;
         max_err     <= '0;
         max_err_a   <= '0;
         max_err_b   <= '0;
      end else if (s2.valid) begin
         sum_abs_err <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
         err_count   <= err_count + (2*WIDTH+1)'(s2.err != '0);
         // Strict compare keeps the earliest pair on ties.
         if (s2.err > max_err) begin
            max_err   <= s2.err;
            max_err_a <= s2.a;
            max_err_b <= s2.b;
         end
      end
   end
endmodule
